// File: rtl/regfile_dump.sv
// Read-side register file dump sequencer: walks an index range on one read port,
// streams each value over valid/ready and holds the CPU stalled for a consistent snapshot.
module regfile_dump #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int SKIP_R0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_idx,
    input  logic [ADDR_W-1:0] last_idx,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              stall,
    output logic              busy,
    output logic              done
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_READ | rd_addr presented, capture rd_data this cycle
    // S_SEND | word offered, waiting for out_ready
    // S_DONE | one-cycle completion pulse, CPU still held
    typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

    localparam bit SKIP = (SKIP_R0 != 0);
    localparam logic [ADDR_W-1:0] IDX_ZERO = '0;
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_MAX  = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                stall_q, stall_d;
    logic                empty_q, empty_d;
    logic [ADDR_W-1:0]   next_idx;
    logic                is_last;

    always_comb begin
        next_idx = out_idx_q + IDX_ONE;
        if (SKIP && next_idx == IDX_ZERO) begin
            next_idx = IDX_ONE;
        end
    end

    // With index 0 skipped, a range ending at 0 really ends at the top index.
    assign is_last = (out_idx_q == last_q) ||
                     (SKIP && last_q == IDX_ZERO && out_idx_q == IDX_MAX);

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        last_d      = last_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        stall_d     = stall_q;
        empty_d     = empty_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    last_d    = last_idx;
                    stall_d   = 1'b1;
                    empty_d   = SKIP && first_idx == IDX_ZERO && last_idx == IDX_ZERO;
                    rd_addr_d = (SKIP && first_idx == IDX_ZERO) ? IDX_ONE : first_idx;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    stall_d     = 1'b0;
                    state_d     = S_IDLE;
                end else if (empty_q) begin
                    state_d = S_DONE;
                end else begin
                    out_data_d  = rd_data;
                    out_idx_d   = rd_addr_q;
                    out_valid_d = 1'b1;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    stall_d     = 1'b0;
                    state_d     = S_IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        rd_addr_d = next_idx;
                        state_d   = S_READ;
                    end
                end
            end
            S_DONE: begin
                stall_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                out_valid_d = 1'b0;
                stall_d     = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            last_q      <= '0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= 1'b0;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            last_q      <= last_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
            empty_q     <= empty_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign stall     = stall_q;
    assign busy      = (state_q != S_IDLE);
    // An abort during the completion cycle suppresses the pulse.
    assign done      = (state_q == S_DONE) && !abort;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: two instances (SKIP_R0=0 and 1) sharing a register file model,
// table-driven range dumps checked through a scoreboard, plus hand-written corner sequences.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i    [2];
    logic        abort_i    [2];
    logic [4:0]  first_i    [2];
    logic [4:0]  last_i     [2];
    logic        ready_i    [2];
    logic [31:0] rd_data_i  [2];
    logic [4:0]  rd_addr_o  [2];
    logic        valid_o    [2];
    logic [31:0] data_o     [2];
    logic [4:0]  idx_o      [2];
    logic        stall_o    [2];
    logic        busy_o     [2];
    logic        done_o     [2];

    logic [31:0] regs [32];

    always #5 clk = ~clk;

    assign rd_data_i[0] = regs[rd_addr_o[0]];
    assign rd_data_i[1] = regs[rd_addr_o[1]];

    regfile_dump #(.ADDR_W(5), .DATA_W(32), .SKIP_R0(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .abort(abort_i[0]),
        .first_idx(first_i[0]), .last_idx(last_i[0]), .rd_addr(rd_addr_o[0]),
        .rd_data(rd_data_i[0]), .out_valid(valid_o[0]), .out_ready(ready_i[0]),
        .out_data(data_o[0]), .out_idx(idx_o[0]), .stall(stall_o[0]),
        .busy(busy_o[0]), .done(done_o[0]));

    regfile_dump #(.ADDR_W(5), .DATA_W(32), .SKIP_R0(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .abort(abort_i[1]),
        .first_idx(first_i[1]), .last_idx(last_i[1]), .rd_addr(rd_addr_o[1]),
        .rd_data(rd_data_i[1]), .out_valid(valid_o[1]), .out_ready(ready_i[1]),
        .out_data(data_o[1]), .out_idx(idx_o[1]), .stall(stall_o[1]),
        .busy(busy_o[1]), .done(done_o[1]));

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } word_t;

    typedef struct {
        int          d;
        logic [4:0]  f;
        logic [4:0]  l;
        int          n;
        logic [19:0] e;
    } vec_t;

    word_t sbq0[$];
    word_t sbq1[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt [2];
    int done_cyc [2];
    int last_hs  [2];
    bit gap_chk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
    endtask

    task automatic monitor();
        word_t w;
        bit    got;
        for (int d = 0; d < 2; d++) begin
            if (rst_n && done_o[d]) begin
                done_cnt[d]++;
                done_cyc[d] = cyc;
                chk("stall_at_done", {63'd0, stall_o[d]}, 64'd1);
            end
            if (rst_n && valid_o[d] && ready_i[d] && !abort_i[d]) begin
                got = 1'b0;
                if (d == 0 && sbq0.size() > 0) begin w = sbq0.pop_front(); got = 1'b1; end
                if (d == 1 && sbq1.size() > 0) begin w = sbq1.pop_front(); got = 1'b1; end
                if (!got) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: dut%0d idx %0d data %0h", d, idx_o[d], data_o[d]);
                end else begin
                    chk("word_idx", {59'd0, idx_o[d]}, {59'd0, w.idx});
                    chk("word_data", {32'd0, data_o[d]}, {32'd0, w.data});
                end
                if (gap_chk && last_hs[d] >= 0)
                    chk("word_spacing", 64'(cyc - last_hs[d]), 64'd2);
                last_hs[d] = cyc;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input int d, input logic [4:0] idx);
        word_t w;
        w.idx  = idx;
        w.data = regs[idx];
        if (d == 0) sbq0.push_back(w);
        else        sbq1.push_back(w);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? sbq0.size() : sbq1.size();
    endfunction

    // Starts a dump, waits for done, checks latency, queue drain and release of stall.
    task automatic run(input vec_t v, input bit spacing, input int restart_at);
        int c;
        int dc0;
        bit seen;
        for (int k = 0; k < v.n; k++) push(v.d, v.e[5*k +: 5]);
        last_hs[v.d] = -1;
        gap_chk      = spacing;
        dc0          = done_cnt[v.d];
        first_i[v.d] = v.f;
        last_i[v.d]  = v.l;
        start_i[v.d] = 1'b1;
        c = cyc;
        tick();
        start_i[v.d] = 1'b0;
        chk("stall_after_start", {63'd0, stall_o[v.d]}, 64'd1);
        chk("busy_after_start", {63'd0, busy_o[v.d]}, 64'd1);
        seen = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (t == restart_at) begin
                first_i[v.d] = 5'd10;
                last_i[v.d]  = 5'd12;
                start_i[v.d] = 1'b1;
            end else begin
                start_i[v.d] = 1'b0;
            end
            tick();
            if (done_cnt[v.d] != dc0) begin
                seen = 1'b1;
                break;
            end
        end
        start_i[v.d] = 1'b0;
        if (!seen) begin
            fail_now("wait_done");
        end else begin
            if (spacing)
                chk("done_latency", 64'(done_cyc[v.d] - c), 64'((v.n == 0) ? 2 : 2 * v.n + 1));
            chk("stall_released", {63'd0, stall_o[v.d]}, 64'd0);
            chk("busy_released", {63'd0, busy_o[v.d]}, 64'd0);
        end
        tick();
        tick();
        chk("done_once", 64'(done_cnt[v.d] - dc0), 64'd1);
        chk("queue_drained", 64'(qsize(v.d)), 64'd0);
    endtask

    task automatic wait_word(input int d, input logic [4:0] idx, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (valid_o[d] && idx_o[d] == idx) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_now("wait_word");
    endtask

    vec_t tbl [7];

    initial begin
        vec_t v;
        bit   ok;
        int   dc0;

        for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * i;
        regs[1]  = 32'h11; regs[2]  = 32'h22; regs[3] = 32'h33;
        regs[30] = 32'hA;  regs[31] = 32'hB;

        //           dut first  last   n  expected indices, first in low bits
        tbl[0] = '{0, 5'd1,  5'd3,  3, {5'd0,  5'd3,  5'd2,  5'd1}};
        tbl[1] = '{0, 5'd30, 5'd1,  4, {5'd1,  5'd0,  5'd31, 5'd30}};
        tbl[2] = '{1, 5'd30, 5'd1,  3, {5'd0,  5'd1,  5'd31, 5'd30}};
        tbl[3] = '{0, 5'd7,  5'd7,  1, {5'd0,  5'd0,  5'd0,  5'd7}};
        tbl[4] = '{1, 5'd0,  5'd0,  0, {5'd0,  5'd0,  5'd0,  5'd0}};
        tbl[5] = '{1, 5'd0,  5'd2,  2, {5'd0,  5'd0,  5'd2,  5'd1}};
        tbl[6] = '{1, 5'd30, 5'd0,  2, {5'd0,  5'd0,  5'd31, 5'd30}};

        for (int d = 0; d < 2; d++) begin
            start_i[d] = 1'b0; abort_i[d] = 1'b0; ready_i[d] = 1'b1;
            first_i[d] = '0;   last_i[d]  = '0;
            done_cnt[d] = 0;   done_cyc[d] = 0; last_hs[d] = -1;
        end
        gap_chk = 1'b0;
        rst_n   = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", {63'd0, valid_o[d]}, 64'd0);
            chk("rst_stall", {63'd0, stall_o[d]}, 64'd0);
            chk("rst_busy",  {63'd0, busy_o[d]},  64'd0);
            chk("rst_done",  {63'd0, done_o[d]},  64'd0);
            chk("rst_addr",  {59'd0, rd_addr_o[d]}, 64'd0);
            chk("rst_idx",   {59'd0, idx_o[d]},   64'd0);
            chk("rst_data",  {32'd0, data_o[d]},  64'd0);
        end
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run(tbl[i], 1'b1, -1);

        // Backpressure on word 2: everything holds for five cycles.
        v = tbl[0];
        for (int k = 0; k < 3; k++) push(0, v.e[5*k +: 5]);
        first_i[0] = 5'd1; last_i[0] = 5'd3; start_i[0] = 1'b1;
        gap_chk = 1'b0;
        dc0 = done_cnt[0];
        tick();
        start_i[0] = 1'b0;
        wait_word(0, 5'd2, ok);
        ready_i[0] = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("bp_valid", {63'd0, valid_o[0]}, 64'd1);
            chk("bp_idx",   {59'd0, idx_o[0]},   64'd2);
            chk("bp_data",  {32'd0, data_o[0]},  64'h22);
            chk("bp_addr",  {59'd0, rd_addr_o[0]}, 64'd2);
        end
        ready_i[0] = 1'b1;
        for (int t = 0; t < 20; t++) tick();
        chk("bp_done_once", 64'(done_cnt[0] - dc0), 64'd1);
        chk("bp_queue", 64'(sbq0.size()), 64'd0);

        // Abort with a same-cycle handshake on word 2: word not delivered, no done.
        push(0, 5'd1);
        first_i[0] = 5'd1; last_i[0] = 5'd3; start_i[0] = 1'b1;
        dc0 = done_cnt[0];
        tick();
        start_i[0] = 1'b0;
        wait_word(0, 5'd2, ok);
        abort_i[0] = 1'b1;
        tick();
        abort_i[0] = 1'b0;
        chk("abort_valid", {63'd0, valid_o[0]}, 64'd0);
        chk("abort_stall", {63'd0, stall_o[0]}, 64'd0);
        chk("abort_busy",  {63'd0, busy_o[0]},  64'd0);
        for (int t = 0; t < 6; t++) tick();
        chk("abort_no_done", 64'(done_cnt[0] - dc0), 64'd0);
        chk("abort_queue", 64'(sbq0.size()), 64'd0);
        run(tbl[0], 1'b1, -1);

        // Start pulsed mid-dump is ignored.
        run(tbl[0], 1'b1, 2);

        // Reset mid-dump.
        ready_i[0] = 1'b0;
        first_i[0] = 5'd1; last_i[0] = 5'd3; start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        tick();
        tick();
        chk("pre_rst_valid", {63'd0, valid_o[0]}, 64'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", {63'd0, valid_o[0]}, 64'd0);
        chk("mid_rst_stall", {63'd0, stall_o[0]}, 64'd0);
        chk("mid_rst_busy",  {63'd0, busy_o[0]},  64'd0);
        chk("mid_rst_addr",  {59'd0, rd_addr_o[0]}, 64'd0);
        chk("mid_rst_idx",   {59'd0, idx_o[0]},   64'd0);
        chk("mid_rst_data",  {32'd0, data_o[0]},  64'd0);
        rst_n = 1'b1;
        ready_i[0] = 1'b1;
        tick();
        run(tbl[1], 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
